// File: rtl/mdio_mgmt_pkg.sv
// mdio_mgmt_pkg: shared definitions for the MDIO management controller.
//   - mgmt_state_t : sequencer FSM states
//   - MII register addresses, BMSR link bit position
//   - power-up init write table plus lookup helpers
// No ports (package).
package mdio_mgmt_pkg;

    typedef enum logic [2:0] {
        WAIT_RST,
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        HOST_ISSUE,
        HOST_WAIT,
        POLL_ISSUE,
        POLL_WAIT
    } mgmt_state_t;

    localparam logic [4:0] BMCR = 5'd0;
    localparam logic [4:0] BMSR = 5'd1;
    localparam logic [4:0] ANAR = 5'd4;
    localparam logic [4:0] GBCR = 5'd9;

    localparam int unsigned BMSR_LINK_BIT = 2;

    localparam logic [4:0]  INIT_REG  [3] = '{ANAR, GBCR, BMCR};
    localparam logic [15:0] INIT_DATA [3] = '{16'h01E1, 16'h0200, 16'h1340};

    // Positions beyond the three-entry table repeat the final (BMCR) entry.
    function automatic logic [4:0] init_reg(input logic [3:0] idx);
        case (idx)
            4'd0:    return INIT_REG[0];
            4'd1:    return INIT_REG[1];
            default: return INIT_REG[2];
        endcase
    endfunction

    function automatic logic [15:0] init_data(input logic [3:0] idx);
        case (idx)
            4'd0:    return INIT_DATA[0];
            4'd1:    return INIT_DATA[1];
            default: return INIT_DATA[2];
        endcase
    endfunction

endpackage

// File: rtl/mdio_mgmt_poll_timer.sv
// mdio_mgmt_poll_timer: free-running BMSR poll interval timer.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : timer runs while high, held at zero while low
//   clear      : drops the pending flag (poll being issued)
//   poll_pend  : set on every wrap at POLL_CYCLES-1; a wrap while already
//                pending is absorbed, so at most one poll is ever owed
module mdio_mgmt_poll_timer #(
    parameter int unsigned POLL_CYCLES = 1250000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic poll_pend
);

    localparam logic [31:0] CNT_LAST = 32'(POLL_CYCLES - 1);

    logic [31:0] cnt;
    logic        wrap;

    assign wrap = enable && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            poll_pend <= 1'b0;
        end else begin
            if (!enable || wrap) cnt <= '0;
            else                 cnt <= cnt + 32'd1;
            // A fresh wrap outranks a coincident clear: that interval is owed too.
            if (wrap)       poll_pend <= 1'b1;
            else if (clear) poll_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/mdio_mgmt_ctrl.sv
// mdio_mgmt_ctrl: power-up sequencer and arbiter in front of the MDIO master.
// Replays the init write table after reset, then serves host requests and
// (optionally) periodic BMSR polls for link state.
//   host_req_*/host_rw/host_reg/host_wdata : host command (valid/ready)
//   host_rdata_valid/host_rdata            : host read result
//   mdio_cmd_*/mdio_rw/mdio_reg/mdio_wdata : command to MDIO master
//   mdio_rdata_valid/mdio_rdata            : read result from master
//   init_done, link_up, busy               : status
// Build option: define MDIO_MGMT_LINK_POLL_EN to include the poll timer,
// POLL states and link_up tracking; otherwise link_up is tied low.
module mdio_mgmt_ctrl
    import mdio_mgmt_pkg::*;
#(
    parameter int unsigned RESET_WAIT_CYCLES = 125000,
    parameter int unsigned POLL_CYCLES       = 1250000,
    parameter int unsigned INIT_LEN          = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic        host_rw,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_wdata,
    output logic        host_rdata_valid,
    output logic [15:0] host_rdata,
    output logic        mdio_cmd_valid,
    input  logic        mdio_cmd_ready,
    output logic        mdio_rw,
    output logic [4:0]  mdio_reg,
    output logic [15:0] mdio_wdata,
    input  logic        mdio_rdata_valid,
    input  logic [15:0] mdio_rdata,
    output logic        init_done,
    output logic        link_up,
    output logic        busy
);

    localparam logic [31:0] RST_LAST  = 32'(RESET_WAIT_CYCLES - 1);
    localparam logic [3:0]  INIT_LAST = 4'(INIT_LEN - 1);

    mgmt_state_t state, state_n;
    logic [31:0] rst_cnt;
    logic [3:0]  idx;
    logic        wr_armed;
    logic        wr_done;
    logic        h_rw;
    logic [4:0]  h_reg;
    logic [15:0] h_wdata;

    // The master drops ready the cycle after accept; wr_armed masks that
    // first WAIT cycle so a write completes no earlier than accept+2.
    assign wr_done = wr_armed && mdio_cmd_ready;

`ifdef MDIO_MGMT_LINK_POLL_EN
    logic poll_pend;
    logic poll_clear;
    logic link_up_q;

    mdio_mgmt_poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_poll_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (init_done),
        .clear    (poll_clear),
        .poll_pend(poll_pend)
    );

    assign link_up = link_up_q;
`else
    logic unused_poll_cfg;
    assign unused_poll_cfg = ^POLL_CYCLES;
    assign link_up = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_RST;
        else       state <= state_n;
    end

    always_comb begin
        state_n        = state;
        mdio_cmd_valid = 1'b0;
        mdio_rw        = 1'b0;
        mdio_reg       = '0;
        mdio_wdata     = '0;
        host_req_ready = 1'b0;
        busy           = 1'b0;
`ifdef MDIO_MGMT_LINK_POLL_EN
        poll_clear     = 1'b0;
`endif
        case (state)
            WAIT_RST: begin
                if (rst_cnt == RST_LAST) state_n = INIT_ISSUE;
            end
            INIT_ISSUE: begin
                busy           = 1'b1;
                mdio_cmd_valid = 1'b1;
                mdio_reg       = init_reg(idx);
                mdio_wdata     = init_data(idx);
                if (mdio_cmd_ready) state_n = INIT_WAIT;
            end
            INIT_WAIT: begin
                busy = 1'b1;
                if (wr_done) state_n = (idx == INIT_LAST) ? IDLE : INIT_ISSUE;
            end
            IDLE: begin
                host_req_ready = init_done;
                if (host_req_valid && init_done) state_n = HOST_ISSUE;
`ifdef MDIO_MGMT_LINK_POLL_EN
                else if (poll_pend) begin
                    state_n    = POLL_ISSUE;
                    poll_clear = 1'b1;
                end
`endif
            end
            HOST_ISSUE: begin
                busy           = 1'b1;
                mdio_cmd_valid = 1'b1;
                mdio_rw        = h_rw;
                mdio_reg       = h_reg;
                mdio_wdata     = h_wdata;
                if (mdio_cmd_ready) state_n = HOST_WAIT;
            end
            HOST_WAIT: begin
                busy = 1'b1;
                if (h_rw ? mdio_rdata_valid : wr_done) state_n = IDLE;
            end
`ifdef MDIO_MGMT_LINK_POLL_EN
            POLL_ISSUE: begin
                busy           = 1'b1;
                mdio_cmd_valid = 1'b1;
                mdio_rw        = 1'b1;
                mdio_reg       = BMSR;
                if (mdio_cmd_ready) state_n = POLL_WAIT;
            end
            POLL_WAIT: begin
                busy = 1'b1;
                if (mdio_rdata_valid) state_n = IDLE;
            end
`endif
            default: state_n = WAIT_RST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt          <= '0;
            idx              <= '0;
            init_done        <= 1'b0;
            wr_armed         <= 1'b0;
            h_rw             <= 1'b0;
            h_reg            <= '0;
            h_wdata          <= '0;
            host_rdata_valid <= 1'b0;
            host_rdata       <= '0;
`ifdef MDIO_MGMT_LINK_POLL_EN
            link_up_q        <= 1'b0;
`endif
        end else begin
            host_rdata_valid <= 1'b0;
            wr_armed         <= busy && !mdio_cmd_valid;

            if (state == WAIT_RST) begin
                idx <= '0;
                if (rst_cnt != RST_LAST) rst_cnt <= rst_cnt + 32'd1;
            end

            if (state == INIT_WAIT && wr_done) begin
                idx <= idx + 4'd1;
                if (idx == INIT_LAST) init_done <= 1'b1;
            end

            if (host_req_ready && host_req_valid) begin
                h_rw    <= host_rw;
                h_reg   <= host_reg;
                h_wdata <= host_wdata;
            end

            if (state == HOST_WAIT && h_rw && mdio_rdata_valid) begin
                host_rdata       <= mdio_rdata;
                host_rdata_valid <= 1'b1;
            end

`ifdef MDIO_MGMT_LINK_POLL_EN
            if (state == POLL_WAIT && mdio_rdata_valid)
                link_up_q <= mdio_rdata[BMSR_LINK_BIT];
`endif
        end
    end

endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// tb_mdio_mgmt_ctrl: directed self-checking bench for mdio_mgmt_ctrl with a
// behavioural MDIO master (drops ready after accept, returns reads after a
// programmable latency). Poll scenarios run when MDIO_MGMT_LINK_POLL_EN is set.
module tb_mdio_mgmt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_rw;
    logic [4:0]  host_reg;
    logic [15:0] host_wdata;
    logic        host_rdata_valid;
    logic [15:0] host_rdata;
    logic        mdio_cmd_valid;
    logic        mdio_cmd_ready;
    logic        mdio_rw;
    logic [4:0]  mdio_reg;
    logic [15:0] mdio_wdata;
    logic        mdio_rdata_valid;
    logic [15:0] mdio_rdata;
    logic        init_done;
    logic        link_up;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // master model state / logs
    int          stall_req  = 0;
    int          stall_seen = 0;
    int          stall_bad  = 0;
    int          rd_lat     = 2;
    logic [15:0] host_val   = '0;
    logic [15:0] bmsr_val   = '0;
    int          n_acc      = 0;
    int          n_poll_done = 0;
    logic [4:0]  acc_reg [64];
    logic        acc_rw  [64];
    logic [15:0] acc_wd  [64];
    int          acc_cyc [64];
    int          cyc     = 0;
    int          t_rv    = 0;
    int          t_hrv   = 0;
    int          n_hrv   = 0;
    int          early_rdy = 0;

    always #4 clk = ~clk;

    mdio_mgmt_ctrl #(
        .RESET_WAIT_CYCLES(16),
        .POLL_CYCLES      (64),
        .INIT_LEN         (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_rw         (host_rw),
        .host_reg        (host_reg),
        .host_wdata      (host_wdata),
        .host_rdata_valid(host_rdata_valid),
        .host_rdata      (host_rdata),
        .mdio_cmd_valid  (mdio_cmd_valid),
        .mdio_cmd_ready  (mdio_cmd_ready),
        .mdio_rw         (mdio_rw),
        .mdio_reg        (mdio_reg),
        .mdio_wdata      (mdio_wdata),
        .mdio_rdata_valid(mdio_rdata_valid),
        .mdio_rdata      (mdio_rdata),
        .init_done       (init_done),
        .link_up         (link_up),
        .busy            (busy)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (host_rdata_valid) begin
            n_hrv++;
            t_hrv = cyc;
        end
        if (host_req_ready && !init_done) early_rdy++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_cmd(input logic rw, input logic [4:0] r, input logic [15:0] d);
        int n;
        host_rw        = rw;
        host_reg       = r;
        host_wdata     = d;
        host_req_valid = 1'b1;
        n = 0;
        while (!host_req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("host_accept", {31'd0, host_req_ready}, 32'd1);
        @(negedge clk);
        host_req_valid = 1'b0;
    endtask

    // MDIO master model
    initial begin : master
        logic        a_rw;
        logic [4:0]  a_reg;
        logic        s_rw;
        logic [4:0]  s_reg;
        logic [15:0] s_wd;
        mdio_cmd_ready   = 1'b1;
        mdio_rdata_valid = 1'b0;
        mdio_rdata       = '0;
        forever begin
            @(negedge clk);
            if (mdio_cmd_valid && stall_req > 0) begin
                s_rw  = mdio_rw;
                s_reg = mdio_reg;
                s_wd  = mdio_wdata;
                mdio_cmd_ready = 1'b0;
                for (int k = 0; k < stall_req; k++) begin
                    @(negedge clk);
                    stall_seen++;
                    if (!(mdio_cmd_valid === 1'b1 && mdio_rw === s_rw &&
                          mdio_reg === s_reg && mdio_wdata === s_wd)) stall_bad++;
                end
                stall_req      = 0;
                mdio_cmd_ready = 1'b1;
            end
            if (mdio_cmd_valid && mdio_cmd_ready) begin
                a_rw  = mdio_rw;
                a_reg = mdio_reg;
                if (n_acc < 64) begin
                    acc_reg[n_acc] = mdio_reg;
                    acc_rw[n_acc]  = mdio_rw;
                    acc_wd[n_acc]  = mdio_wdata;
                    acc_cyc[n_acc] = cyc;
                end
                n_acc++;
                @(negedge clk);
                mdio_cmd_ready = 1'b0;
                if (a_rw) begin
                    repeat (rd_lat) @(negedge clk);
                    mdio_rdata       = (a_reg == 5'd1) ? bmsr_val : host_val;
                    mdio_rdata_valid = 1'b1;
                    t_rv = cyc;
                    if (a_reg == 5'd1) n_poll_done++;
                    @(negedge clk);
                    mdio_rdata_valid = 1'b0;
                end else begin
                    repeat (2) @(negedge clk);
                end
                mdio_cmd_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int b_acc;
        int b_hrv;
        logic lk;
`ifdef MDIO_MGMT_LINK_POLL_EN
        int b_p;
`endif
        reset          = 1'b1;
        host_req_valid = 1'b0;
        host_rw        = 1'b0;
        host_reg       = '0;
        host_wdata     = '0;
        stall_req      = 20;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_cmd_valid", {31'd0, mdio_cmd_valid}, 32'd0);
        chk("rst_host_ready", {31'd0, host_req_ready}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_link_up", {31'd0, link_up}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hrv", {31'd0, host_rdata_valid}, 32'd0);
        chk("rst_fields", {10'd0, mdio_rw, mdio_reg, mdio_wdata}, 32'd0);

        // init sequence with a 20-cycle ready stall on the first command
        reset = 1'b0;
        n = 0;
        while (!init_done && n < 400) begin @(negedge clk); n++; end
        chk("init_done_rise", {31'd0, init_done}, 32'd1);
        chk("init_acc_count", n_acc, 3);
        chk("init_busy_at_done", {31'd0, busy}, 32'd0);
        chk("init_w0", {10'd0, acc_rw[0], acc_reg[0], acc_wd[0]}, {10'd0, 1'b0, 5'd4, 16'h01E1});
        chk("init_w1", {10'd0, acc_rw[1], acc_reg[1], acc_wd[1]}, {10'd0, 1'b0, 5'd9, 16'h0200});
        chk("init_w2", {10'd0, acc_rw[2], acc_reg[2], acc_wd[2]}, {10'd0, 1'b0, 5'd0, 16'h1340});
        chk("stall_cycles", stall_seen, 20);
        chk("stall_stable", stall_bad, 0);
        chk("ready_before_init", early_rdy, 0);
        chk("ready_after_init", {31'd0, host_req_ready}, 32'd1);

        // host read of reg 5
        host_val = 16'hBEEF;
        b_acc = n_acc;
        b_hrv = n_hrv;
        lk    = link_up;
        host_cmd(1'b1, 5'd5, 16'h0000);
        n = 0;
        while (n_hrv == b_hrv && n < 50) begin @(negedge clk); n++; end
        chk("hrd_data", {16'd0, host_rdata}, 32'h0000BEEF);
        chk("hrd_latency", t_hrv - t_rv, 1);
        repeat (5) @(negedge clk);
        chk("hrd_one_pulse", n_hrv - b_hrv, 1);
        chk("hrd_link_same", {31'd0, link_up}, {31'd0, lk});
        chk("hrd_cmd", {26'd0, acc_rw[b_acc], acc_reg[b_acc]}, {26'd0, 1'b1, 5'd5});

        // host write: no response pulse, read data held
        b_acc = n_acc;
        b_hrv = n_hrv;
        host_cmd(1'b0, 5'h10, 16'h1234);
        repeat (8) @(negedge clk);
        chk("hwr_cmd", {10'd0, acc_rw[b_acc], acc_reg[b_acc], acc_wd[b_acc]}, {10'd0, 1'b0, 5'h10, 16'h1234});
        chk("hwr_no_pulse", n_hrv - b_hrv, 0);
        chk("hwr_rdata_held", {16'd0, host_rdata}, 32'h0000BEEF);

`ifdef MDIO_MGMT_LINK_POLL_EN
        // link up then down from successive polls
        b_hrv    = n_hrv;
        bmsr_val = 16'h0004;
        b_p = n_poll_done;
        n = 0;
        while (n_poll_done == b_p && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("poll_link_up", {31'd0, link_up}, 32'd1);
        bmsr_val = 16'h0000;
        b_p = n_poll_done;
        n = 0;
        while (n_poll_done == b_p && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("poll_link_down", {31'd0, link_up}, 32'd0);
        chk("poll_no_hrv", n_hrv - b_hrv, 0);

        // host vs pending poll: long host read lets the poll become pending
        rd_lat   = 80;
        host_val = 16'hCAFE;
        b_acc    = n_acc;
        host_cmd(1'b1, 5'd3, 16'h0000);
        host_cmd(1'b0, 5'h11, 16'h5A5A);
        rd_lat = 2;
        n = 0;
        while (n_acc < b_acc + 3 && n < 300) begin @(negedge clk); n++; end
        chk("arb_first", {26'd0, acc_rw[b_acc], acc_reg[b_acc]}, {26'd0, 1'b1, 5'd3});
        chk("arb_second", {10'd0, acc_rw[b_acc+1], acc_reg[b_acc+1], acc_wd[b_acc+1]}, {10'd0, 1'b0, 5'h11, 16'h5A5A});
        chk("arb_poll", {26'd0, acc_rw[b_acc+2], acc_reg[b_acc+2]}, {26'd0, 1'b1, 5'd1});
        chk("arb_poll_gap", acc_cyc[b_acc+2] - acc_cyc[b_acc+1], 5);

        // bring link up so the reset test can see it cleared
        bmsr_val = 16'h0004;
        b_p = n_poll_done;
        n = 0;
        while (n_poll_done == b_p && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("pre_rst_link", {31'd0, link_up}, 32'd1);
`else
        b_acc = n_acc;
        repeat (150) @(negedge clk);
        chk("nopoll_link", {31'd0, link_up}, 32'd0);
        chk("nopoll_no_cmds", n_acc - b_acc, 0);
`endif

        // reset during HOST_WAIT
        rd_lat = 10;
        b_hrv  = n_hrv;
        host_cmd(1'b1, 5'd7, 16'h0000);
        n = 0;
        while (!(busy && !mdio_cmd_valid) && n < 20) begin @(negedge clk); n++; end
        chk("in_host_wait", {30'd0, busy, mdio_cmd_valid}, 32'd2);
        reset = 1'b1;
        #1;
        chk("arst_cmd_valid", {31'd0, mdio_cmd_valid}, 32'd0);
        chk("arst_init_done", {31'd0, init_done}, 32'd0);
        chk("arst_link_up", {31'd0, link_up}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        b_acc = n_acc;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        rd_lat = 2;
        n = 0;
        while (!init_done && n < 400) begin @(negedge clk); n++; end
        chk("replay_done", {31'd0, init_done}, 32'd1);
        chk("replay_count", n_acc - b_acc, 3);
        chk("replay_w0", {10'd0, acc_rw[b_acc], acc_reg[b_acc], acc_wd[b_acc]}, {10'd0, 1'b0, 5'd4, 16'h01E1});
        chk("replay_w1", {10'd0, acc_rw[b_acc+1], acc_reg[b_acc+1], acc_wd[b_acc+1]}, {10'd0, 1'b0, 5'd9, 16'h0200});
        chk("replay_w2", {10'd0, acc_rw[b_acc+2], acc_reg[b_acc+2], acc_wd[b_acc+2]}, {10'd0, 1'b0, 5'd0, 16'h1340});
        chk("aborted_no_hrv", n_hrv - b_hrv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
